ibex_bloom_unit: RTL and testbench

Parametrised Bloom-filter coprocessor for the Ibex EX stage. It generalises the fixed custom bloom unit:
- configurable array size and hash count;
- optional counting mode with delete;
- an occupancy counter;
- a multi-cycle probe FSM that speaks the EX-stage enable/valid handshake.

It sits beside the ALU and multdiv inside the EX block. It takes the key from RS1/RS2 and returns match, error and occupancy to writeback.

---
 rtl/ibex_bloom_pkg.sv | 28 ++
 rtl/ibex_bloom_hash.sv | 28 ++
 rtl/ibex_bloom_unit.sv | 193 +++++++++++++++++++
 tb/tb_ibex_bloom_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_bloom_pkg.sv
// Shared types and constants for the Ibex Bloom-filter coprocessor.
package ibex_bloom_pkg;

    typedef enum logic [1:0] {
        BloomInsert = 2'b00,
        BloomCheck  = 2'b01,
        BloomRemove = 2'b10,
        BloomClear  = 2'b11
    } bloom_op_e;

    // FSM encoding kept as plain constants so older code can compare raw values.
    typedef logic [2:0] bloom_state_e;
    localparam bloom_state_e StIdle  = 3'd0;
    localparam bloom_state_e StHash  = 3'd1;
    localparam bloom_state_e StProbe = 3'd2;
    localparam bloom_state_e StClear = 3'd3;
    localparam bloom_state_e StDone  = 3'd4;

    localparam logic [31:0] BloomMulA = 32'h9E3779B1;
    localparam logic [31:0] BloomMulB = 32'h85EBCA6B;
    localparam int unsigned BloomRotA = 16;
    localparam int unsigned BloomRotB = 7;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/ibex_bloom_hash.sv
// Combinational double-hash of a 64-bit key into two filter indices.
module ibex_bloom_hash
    import ibex_bloom_pkg::*;
#(
    parameter int unsigned IdxW = 10
) (
    input  logic [31:0]     key_lo_i,
    input  logic [31:0]     key_hi_i,
    output logic [IdxW-1:0] h1_o,
    output logic [IdxW-1:0] h2_o
);

    logic [31:0] mix_a;
    logic [31:0] mix_b;
    logic [31:0] prod_a;
    logic [31:0] prod_b;

    // Multiplicative hashing; h2 is forced odd so the probe stride visits distinct entries.
    always_comb begin
        mix_a  = key_lo_i ^ rotl32(key_hi_i, BloomRotA);
        mix_b  = key_hi_i ^ rotl32(key_lo_i, BloomRotB);
        prod_a = mix_a * BloomMulA;
        prod_b = mix_b * BloomMulB;
        h1_o   = prod_a[31 -: IdxW];
        h2_o   = prod_b[31 -: IdxW] | IdxW'(1);
    end

endmodule

// File: rtl/ibex_bloom_unit.sv
// Bloom-filter coprocessor: multi-cycle insert/check/remove/clear with occupancy count.
module ibex_bloom_unit
    import ibex_bloom_pkg::*;
#(
    parameter  int unsigned NumBits    = 1024,
    parameter  int unsigned NumHashes  = 3,
    parameter  int unsigned CountWidth = 0,
    localparam int unsigned IdxW       = $clog2(NumBits),
    localparam int unsigned CntW       = $clog2(NumBits + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [1:0]      op_i,
    input  logic [31:0]     key_lo_i,
    input  logic [31:0]     key_hi_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic            match_o,
    output logic            error_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned EntryW = (CountWidth == 0) ? 1 : CountWidth;
    localparam int unsigned PW     = (NumHashes > 1) ? $clog2(NumHashes) : 1;

    bloom_state_e    state_q, state_d;
    bloom_op_e       op_q, op_d;
    logic [31:0]     key_lo_q, key_lo_d;
    logic [31:0]     key_hi_q, key_hi_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] h2_q, h2_d;
    logic [PW-1:0]   p_q, p_d;
    logic            run_q, run_d;
    logic            match_q, match_d;
    logic            error_q, error_d;
    logic [CntW-1:0] count_q, count_d;

    logic [IdxW-1:0] hash_h1;
    logic [IdxW-1:0] hash_h2;

    logic [EntryW-1:0] entries_q [NumBits];
    logic [EntryW-1:0] entry_old;
    logic [EntryW-1:0] entry_new;
    logic              entry_we;
    logic              clear_all;

    ibex_bloom_hash #(
        .IdxW(IdxW)
    ) u_hash (
        .key_lo_i(key_lo_q),
        .key_hi_i(key_hi_q),
        .h1_o    (hash_h1),
        .h2_o    (hash_h2)
    );

    assign entry_old = entries_q[idx_q];
    // Every PROBE cycle writes back; Check writes the old value unchanged.
    assign entry_we  = (state_q == StProbe);

    if (CountWidth == 0) begin : g_bit_mode
        // Remove never reaches PROBE in this mode, so only Insert changes an entry.
        assign entry_new = (op_q == BloomInsert) ? 1'b1 : entry_old;
    end else begin : g_count_mode
        logic sat;
        assign sat = &entry_old;
        // Saturating counter; a saturated entry is sticky under Remove.
        always_comb begin
            entry_new = entry_old;
            if (op_q == BloomInsert && !sat) begin
                entry_new = entry_old + EntryW'(1);
            end else if (op_q == BloomRemove && !sat && entry_old != '0) begin
                entry_new = entry_old - EntryW'(1);
            end
        end
    end

    // Next-state, probe bookkeeping and occupancy tracking.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        key_lo_d  = key_lo_q;
        key_hi_d  = key_hi_q;
        idx_d     = idx_q;
        h2_d      = h2_q;
        p_d       = p_q;
        run_d     = run_q;
        match_d   = match_q;
        error_d   = error_q;
        count_d   = count_q;
        clear_all = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    op_d     = bloom_op_e'(op_i);
                    key_lo_d = key_lo_i;
                    key_hi_d = key_hi_i;
                    if (op_i == BloomClear) begin
                        state_d = StClear;
                    end else if (op_i == BloomRemove && CountWidth == 0) begin
                        state_d = StDone;
                        match_d = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = StHash;
                    end
                end
            end
            StHash: begin
                idx_d   = hash_h1;
                h2_d    = hash_h2;
                p_d     = '0;
                run_d   = 1'b1;
                state_d = StProbe;
            end
            StProbe: begin
                run_d = run_q & (entry_old != '0);
                if (entry_old == '0 && entry_new != '0) begin
                    count_d = count_q + CntW'(1);
                end else if (entry_old != '0 && entry_new == '0) begin
                    count_d = count_q - CntW'(1);
                end
                idx_d = idx_q + h2_q;
                p_d   = p_q + PW'(1);
                if (p_q == PW'(NumHashes - 1)) begin
                    state_d = StDone;
                    match_d = run_d;
                    error_d = 1'b0;
                end
            end
            StClear: begin
                clear_all = 1'b1;
                count_d   = '0;
                match_d   = 1'b0;
                error_d   = 1'b0;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and result registers; reset aborts any op in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op_q     <= BloomInsert;
            key_lo_q <= '0;
            key_hi_q <= '0;
            idx_q    <= '0;
            h2_q     <= '0;
            p_q      <= '0;
            run_q    <= 1'b0;
            match_q  <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_lo_q <= key_lo_d;
            key_hi_q <= key_hi_d;
            idx_q    <= idx_d;
            h2_q     <= h2_d;
            p_q      <= p_d;
            run_q    <= run_d;
            match_q  <= match_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    // Filter storage: single write port, whole-array clear on reset or Clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_all) begin
            for (int i = 0; i < NumBits; i++) begin
                entries_q[i] <= '0;
            end
        end else if (entry_we) begin
            entries_q[idx_q] <= entry_new;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign valid_o = (state_q == StDone);
    assign match_o = match_q;
    assign error_o = error_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_ibex_bloom_unit.sv
// Self-checking bench: bit-mode and counting-mode instances against a behavioural filter model.
module tb_ibex_bloom_unit;

    localparam int OpIns = 0;
    localparam int OpChk = 1;
    localparam int OpRem = 2;
    localparam int OpClr = 3;

    typedef struct {
        bit m;
        bit e;
        int cnt;
        int lat;
    } exp_t;

    logic        clk;
    logic        rst   [2];
    logic        en    [2];
    logic [1:0]  op_s  [2];
    logic [31:0] klo   [2];
    logic [31:0] khi   [2];
    logic        busy  [2];
    logic        valid [2];
    logic        match [2];
    logic        error [2];
    logic [10:0] cnt   [2];

    int   total = 0;
    int   bad   = 0;
    int   mdl   [2][1024];
    int   mcnt  [2];
    exp_t sbq   [$];

    ibex_bloom_unit #(.NumBits(1024), .NumHashes(3), .CountWidth(0)) u_dut_bit (
        .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .op_i(op_s[0]),
        .key_lo_i(klo[0]), .key_hi_i(khi[0]), .busy_o(busy[0]), .valid_o(valid[0]),
        .match_o(match[0]), .error_o(error[0]), .count_o(cnt[0])
    );

    ibex_bloom_unit #(.NumBits(1024), .NumHashes(3), .CountWidth(4)) u_dut_cnt (
        .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .op_i(op_s[1]),
        .key_lo_i(klo[1]), .key_hi_i(khi[1]), .busy_o(busy[1]), .valid_o(valid[1]),
        .match_o(match[1]), .error_o(error[1]), .count_o(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bhash(input logic [31:0] lo, input logic [31:0] hi,
                         output int h1, output int h2);
        logic [31:0] a, b, pa, pb;
        a  = lo ^ {hi[15:0], hi[31:16]};
        b  = hi ^ {lo[24:0], lo[31:25]};
        pa = a * 32'h9E3779B1;
        pb = b * 32'h85EBCA6B;
        h1 = int'(pa[31:22]);
        h2 = int'(pb[31:22]) | 1;
    endtask

    task automatic model_clear(input int s);
        for (int i = 0; i < 1024; i++) mdl[s][i] = 0;
        mcnt[s] = 0;
    endtask

    task automatic model_op(input int s, input int op, input logic [31:0] lo,
                            input logic [31:0] hi, output exp_t ex);
        int h1, h2, idx, v, nv, maxv;
        bit m;
        maxv = (s == 0) ? 1 : 15;
        ex.e = 0;
        if (op == OpClr) begin
            model_clear(s);
            ex.m = 0; ex.lat = 2;
        end else if (op == OpRem && s == 0) begin
            ex.m = 0; ex.e = 1; ex.lat = 1;
        end else begin
            bhash(lo, hi, h1, h2);
            idx = h1;
            m = 1;
            for (int p = 0; p < 3; p++) begin
                v = mdl[s][idx];
                m = m & (v != 0);
                nv = v;
                if (op == OpIns && v < maxv) nv = v + 1;
                if (op == OpRem && v != 0 && v != maxv) nv = v - 1;
                if (v == 0 && nv != 0) mcnt[s]++;
                if (v != 0 && nv == 0) mcnt[s]--;
                mdl[s][idx] = nv;
                idx = (idx + h2) % 1024;
            end
            ex.m = m; ex.lat = 5;
        end
        ex.cnt = mcnt[s];
    endtask

    // Issue one op, wait for its valid_o, compare against the scoreboard head.
    task automatic do_op(input string name, input int s, input int op, input logic [31:0] lo,
                         input logic [31:0] hi, output bit m_out);
        exp_t ex;
        int   lat;
        model_op(s, op, lo, hi, ex);
        sbq.push_back(ex);
        en[s] = 1'b1; op_s[s] = 2'(op); klo[s] = lo; khi[s] = hi;
        @(posedge clk); #1;
        en[s] = 1'b0;
        lat = 1;
        while (valid[s] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ex = sbq.pop_front();
        total++;
        if (lat !== ex.lat) begin
            bad++; $display("FAIL %s latency: got %0d expected %0d", name, lat, ex.lat);
        end
        total++;
        if (match[s] !== ex.m) begin
            bad++; $display("FAIL %s match: got %b expected %b", name, match[s], ex.m);
        end
        total++;
        if (error[s] !== ex.e) begin
            bad++; $display("FAIL %s error: got %b expected %b", name, error[s], ex.e);
        end
        total++;
        if (cnt[s] !== 11'(ex.cnt)) begin
            bad++; $display("FAIL %s count: got %0d expected %0d", name, cnt[s], ex.cnt);
        end
        m_out = match[s];
        @(posedge clk); #1;
        total++;
        if (valid[s] !== 1'b0 || busy[s] !== 1'b0) begin
            bad++; $display("FAIL %s idle after done: valid=%b busy=%b expected 0/0",
                            name, valid[s], busy[s]);
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        model_clear(0); model_clear(1);
        for (int s = 0; s < 2; s++) begin
            total++;
            if ({busy[s], valid[s], match[s], error[s]} !== 4'b0 || cnt[s] !== 11'd0) begin
                bad++;
                $display("FAIL reset[%0d]: busy=%b valid=%b match=%b error=%b count=%0d expected all 0",
                         s, busy[s], valid[s], match[s], error[s], cnt[s]);
            end
        end
    endtask

    task automatic test_basic();
        bit m;
        do_op("basic_check_empty", 0, OpChk, 32'h12345678, 32'h0, m);
        total++;
        if (m !== 1'b0 || cnt[0] !== 11'd0) begin
            bad++; $display("FAIL basic_empty: match=%b count=%0d expected 0/0", m, cnt[0]);
        end
        do_op("basic_insert", 0, OpIns, 32'h12345678, 32'h0, m);
        total++;
        if (cnt[0] < 11'd1 || cnt[0] > 11'd3 || m !== 1'b0) begin
            bad++; $display("FAIL basic_insert: count=%0d match=%b expected 1..3/0", cnt[0], m);
        end
        do_op("basic_check_hit", 0, OpChk, 32'h12345678, 32'h0, m);
        total++;
        if (m !== 1'b1) begin
            bad++; $display("FAIL basic_hit: match=%b expected 1", m);
        end
    endtask

    task automatic test_clear();
        bit m;
        for (int i = 0; i < 10; i++) begin
            do_op("clear_fill", 0, OpIns, 32'(i * 32'h1111 + 5), 32'(i), m);
        end
        do_op("clear_op", 0, OpClr, 32'h0, 32'h0, m);
        total++;
        if (cnt[0] !== 11'd0) begin
            bad++; $display("FAIL clear_count: got %0d expected 0", cnt[0]);
        end
        do_op("clear_check", 0, OpChk, 32'(3 * 32'h1111 + 5), 32'd3, m);
        total++;
        if (m !== 1'b0) begin
            bad++; $display("FAIL clear_check_miss: match=%b expected 0", m);
        end
    endtask

    task automatic test_remove_err();
        bit m;
        do_op("rerr_insert", 0, OpIns, 32'hCAFEF00D, 32'h0BADBEEF, m);
        do_op("rerr_remove", 0, OpRem, 32'hCAFEF00D, 32'h0BADBEEF, m);
        do_op("rerr_check", 0, OpChk, 32'hCAFEF00D, 32'h0BADBEEF, m);
        total++;
        if (m !== 1'b1) begin
            bad++; $display("FAIL rerr_array_kept: match=%b expected 1", m);
        end
    endtask

    task automatic test_counting();
        bit m;
        do_op("cnt_clear", 1, OpClr, 32'h0, 32'h0, m);
        do_op("cnt_ins1", 1, OpIns, 32'hA5A5A5A5, 32'h00000011, m);
        do_op("cnt_ins2", 1, OpIns, 32'hA5A5A5A5, 32'h00000011, m);
        do_op("cnt_rem1", 1, OpRem, 32'hA5A5A5A5, 32'h00000011, m);
        do_op("cnt_chk1", 1, OpChk, 32'hA5A5A5A5, 32'h00000011, m);
        total++;
        if (m !== 1'b1) begin
            bad++; $display("FAIL cnt_after_one_remove: match=%b expected 1", m);
        end
        do_op("cnt_rem2", 1, OpRem, 32'hA5A5A5A5, 32'h00000011, m);
        do_op("cnt_chk2", 1, OpChk, 32'hA5A5A5A5, 32'h00000011, m);
        total++;
        if (m !== 1'b0 || cnt[1] !== 11'd0) begin
            bad++; $display("FAIL cnt_after_two_removes: match=%b count=%0d expected 0/0", m, cnt[1]);
        end
    endtask

    task automatic test_saturation();
        bit m;
        do_op("sat_clear", 1, OpClr, 32'h0, 32'h0, m);
        for (int i = 0; i < 16; i++) do_op("sat_ins", 1, OpIns, 32'h00C0FFEE, 32'h7, m);
        for (int i = 0; i < 20; i++) do_op("sat_rem", 1, OpRem, 32'h00C0FFEE, 32'h7, m);
        do_op("sat_chk", 1, OpChk, 32'h00C0FFEE, 32'h7, m);
        total++;
        if (m !== 1'b1) begin
            bad++; $display("FAIL sat_sticky: match=%b expected 1", m);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        en[0] = 1'b1; op_s[0] = 2'(OpIns); klo[0] = 32'h13579BDF; khi[0] = 32'h2468ACE0;
        @(posedge clk); #1;
        en[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        model_clear(0);
        total++;
        if (busy[0] !== 1'b0 || cnt[0] !== 11'd0) begin
            bad++; $display("FAIL rst_mid: busy=%b count=%0d expected 0/0", busy[0], cnt[0]);
        end
        // Reset and en together: the op must be dropped.
        rst[0] = 1'b1; en[0] = 1'b1; op_s[0] = 2'(OpIns);
        @(posedge clk); #1;
        rst[0] = 1'b0; en[0] = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid[0] === 1'b1) nv++;
            @(posedge clk); #1;
        end
        total++;
        if (nv != 0 || cnt[0] !== 11'd0 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL rst_drop: valids=%0d count=%0d busy=%b expected 0/0/0",
                            nv, cnt[0], busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        int   nv, lat;
        bit   m;
        model_op(0, OpIns, 32'hDEAD0001, 32'h0000BEEF, ex);
        sbq.push_back(ex);
        en[0] = 1'b1; op_s[0] = 2'(OpIns); klo[0] = 32'hDEAD0001; khi[0] = 32'h0000BEEF;
        @(posedge clk); #1;
        // Hold a Clear request while busy; it must be ignored.
        op_s[0] = 2'(OpClr);
        nv = 0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) en[0] = 1'b0;
            if (valid[0] === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    ex = sbq.pop_front();
                    lat = c;
                    total++;
                    if (match[0] !== ex.m || cnt[0] !== 11'(ex.cnt) || lat != ex.lat) begin
                        bad++;
                        $display("FAIL busy_ignore_result: match=%b count=%0d lat=%0d expected %b/%0d/%0d",
                                 match[0], cnt[0], lat, ex.m, ex.cnt, ex.lat);
                    end
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (nv != 1) begin
            bad++; $display("FAIL busy_ignore_valids: got %0d expected 1", nv);
        end
        do_op("b2b_check", 0, OpChk, 32'hDEAD0001, 32'h0000BEEF, m);
        do_op("b2b_check2", 0, OpChk, 32'hDEAD0001, 32'h0000BEEF, m);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; en[s] = 1'b0; op_s[s] = 2'b00; klo[s] = '0; khi[s] = '0;
        end
        test_reset();
        test_basic();
        test_clear();
        test_remove_err();
        test_counting();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
